bus_dest_latch: RTL and testbench
=================================

Name: bus_dest_latch

Overview:
Receive-side end of the shared 32-bit datapath bus. The source side drives the bus from one of six sources using a one-hot select. This block captures the bus value into one of six destination holding registers, chosen by a one-hot load select. Each destination has a valid/ack handshake toward its consumer, and the block back-pressures the bus driver while the addressed slot is still occupied.

Parameters:
WIDTH, 32, bus and destination register width
NDEST, 6, number of destination slots (one-hot select width)
CNTW, 8, width of saturating drop counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
bus_in  input  WIDTH  shared bus value
bus_valid  input  1  driver presents a word this cycle
lSel  input  NDEST  one-hot destination select; lowest set bit wins
bus_ready  output  1  word accepted this cycle (combinational)
dst_data  output  NDEST*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH]
dst_valid  output  NDEST  slot k holds unconsumed data
dst_ack  input  NDEST  consumer k takes slot k this cycle
err_nosel  output  1  sticky: a word was offered with lSel == 0
drop_cnt  output  CNTW  count of words offered with lSel == 0, saturating
err_clr  input  1  clears err_nosel and drop_cnt

Behaviour:
- Reset (async, active-high): all dst_data = 0, dst_valid = 0, err_nosel = 0, drop_cnt = 0. It takes effect immediately, including mid-transfer. Any pending word is lost and no capture occurs on the release edge unless the handshake is met.
- Select resolve: tgt = index of lowest set bit of lSel. This matches the priority order on the source side, so 6'b000110 selects slot 1. Bits above the winner are ignored.
- Slot free condition: free[k] = ~dst_valid[k] | dst_ack[k].
- bus_ready = (lSel == 0) | free[tgt]. It is purely combinational and has no dependency on bus_valid.
- Capture: on a rising edge with bus_valid & bus_ready & (lSel != 0):
  - dst_data[tgt] <= bus_in
  - dst_valid[tgt] <= 1
- Capture latency: data and valid are visible the cycle after the accepting edge.
- Consume: on a rising edge with dst_ack[k] & dst_valid[k] and no capture into k, dst_valid[k] <= 0. dst_data[k] holds its last value and is not cleared.
- Ack on an invalid slot is ignored.
- Simultaneous ack and capture on the same slot: the new word is written and dst_valid[k] stays 1 (pass-through, no bubble).
- Acks on other slots are independent. Multiple slots may be acked in the same cycle.
- Stall: when bus_valid is high and bus_ready is low, nothing is written. The driver holds bus_in and lSel until bus_ready goes high.
- No-select: when bus_valid is high and lSel == 0, the word is accepted (bus_ready = 1) and discarded. On that edge:
  - err_nosel <= 1
  - drop_cnt <= drop_cnt + 1, saturating at 2^CNTW - 1
- err_clr has priority over a same-cycle no-select event: both outputs go to 0.
- At most one slot is written per cycle. No internal FIFO depth: each slot is a single entry (full/empty = dst_valid).

Test Plan:
1. Reset, then bus_valid=1, lSel=6'b000100, bus_in=32'hDEAD_BEEF for one cycle -> bus_ready=1; next cycle dst_valid=6'b000100 and slot 2 = 32'hDEAD_BEEF; others remain 0.
2. Slot 2 valid, no ack, offer lSel=6'b000100, bus_in=32'h1234 for 3 cycles -> bus_ready=0 and slot 2 unchanged. Assert dst_ack[2] in cycle 3 -> bus_ready=1 that cycle; slot 2 = 32'h1234 and dst_valid[2] stays 1.
3. lSel=6'b101010, bus_in=32'h5 -> only slot 1 captures 5; dst_valid=6'b000010.
4. bus_valid=1, lSel=0 for 300 consecutive cycles -> bus_ready=1 throughout, err_nosel=1, drop_cnt=255. Then err_clr=1 for one cycle -> both read 0 the following cycle.
5. Slots 0 and 5 valid, ack both in one cycle while capturing into slot 3 -> dst_valid=6'b001000.
6. Assert rst asynchronously mid-cycle while slot 4 is valid and a word is offered -> outputs clear immediately; after release, no capture until the next handshake edge.

Source files
------------

// File: rtl/bus_dest_latch_if.sv
// Shared datapath bus as seen by the receive side: word, valid, one-hot load select, ready.
`timescale 1ns/1ps

interface bus_dest_latch_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NDEST = 6
);
    logic [WIDTH-1:0] bus_in;
    logic             bus_valid;
    logic [NDEST-1:0] lSel;
    logic             bus_ready;

    modport master (
        output bus_in,
        output bus_valid,
        output lSel,
        input  bus_ready
    );

    modport slave (
        input  bus_in,
        input  bus_valid,
        input  lSel,
        output bus_ready
    );
endinterface

// File: rtl/bus_dest_latch.sv
// Receive-side bus latch: captures the bus word into one of NDEST single-entry slots,
// each with a valid/ack handshake, and back-pressures the driver while the target slot is occupied.
`timescale 1ns/1ps

module bus_dest_latch #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NDEST = 6,
    parameter int unsigned CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_dest_latch_if.slave        bus,
    output logic [NDEST*WIDTH-1:0] dst_data,
    output logic [NDEST-1:0]       dst_valid,
    input  logic [NDEST-1:0]       dst_ack,
    output logic                   err_nosel,
    output logic [CNTW-1:0]        drop_cnt,
    input  logic                   err_clr
);

    logic [NDEST*WIDTH-1:0] dst_data_q,  dst_data_d;
    logic [NDEST-1:0]       dst_valid_q, dst_valid_d;
    logic                   err_nosel_q, err_nosel_d;
    logic [CNTW-1:0]        drop_cnt_q,  drop_cnt_d;

    logic [NDEST-1:0] sel_oh_c;
    logic [NDEST-1:0] free_c;
    logic [NDEST-1:0] cap_c;
    logic             any_sel_c;
    logic             ready_c;
    logic             nosel_evt_c;

    // Lowest set bit of lSel wins, matching the source-side priority.
    always_comb begin
        sel_oh_c    = bus.lSel & (~bus.lSel + NDEST'(1));
        any_sel_c   = |bus.lSel;
        free_c      = ~dst_valid_q | dst_ack;
        ready_c     = ~any_sel_c | (|(sel_oh_c & free_c));
        cap_c       = sel_oh_c & {NDEST{bus.bus_valid & ready_c}};
        nosel_evt_c = bus.bus_valid & ~any_sel_c;
    end

    assign bus.bus_ready = ready_c;

    // Capture beats consume on the same slot so a pass-through leaves no bubble.
    always_comb begin
        dst_data_d  = dst_data_q;
        dst_valid_d = dst_valid_q;
        for (int k = 0; k < int'(NDEST); k++) begin
            if (cap_c[k]) begin
                dst_data_d[k*WIDTH +: WIDTH] = bus.bus_in;
                dst_valid_d[k]               = 1'b1;
            end else if (dst_ack[k] && dst_valid_q[k]) begin
                dst_valid_d[k] = 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle no-select drop; the counter saturates.
    always_comb begin
        err_nosel_d = err_nosel_q;
        drop_cnt_d  = drop_cnt_q;
        if (err_clr) begin
            err_nosel_d = 1'b0;
            drop_cnt_d  = '0;
        end else if (nosel_evt_c) begin
            err_nosel_d = 1'b1;
            if (drop_cnt_q != {CNTW{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_data_q  <= '0;
            dst_valid_q <= '0;
            err_nosel_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            dst_data_q  <= dst_data_d;
            dst_valid_q <= dst_valid_d;
            err_nosel_q <= err_nosel_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign dst_data  = dst_data_q;
    assign dst_valid = dst_valid_q;
    assign err_nosel = err_nosel_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_bus_dest_latch.sv
// Randomized and directed bench for bus_dest_latch against a slot-array reference model.
`timescale 1ns/1ps

module tb_bus_dest_latch;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NDEST = 6;
    localparam int unsigned CNTW  = 8;
    localparam int unsigned DW    = NDEST * WIDTH;
    localparam int unsigned CMAX  = (1 << CNTW) - 1;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     dst_data;
    logic [NDEST-1:0]  dst_valid;
    logic [NDEST-1:0]  dst_ack;
    logic              err_nosel;
    logic [CNTW-1:0]   drop_cnt;
    logic              err_clr;

    bus_dest_latch_if #(.WIDTH(WIDTH), .NDEST(NDEST)) bus_if ();

    bus_dest_latch #(.WIDTH(WIDTH), .NDEST(NDEST), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ack   (dst_ack),
        .err_nosel (err_nosel),
        .drop_cnt  (drop_cnt),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [WIDTH-1:0] m_data [NDEST];
    bit               m_valid[NDEST];
    bit               m_err;
    int               m_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < int'(NDEST); k++) begin
            m_data[k]  = '0;
            m_valid[k] = 0;
        end
        m_err = 0;
        m_cnt = 0;
    endfunction

    function automatic int lowest(input logic [NDEST-1:0] sel);
        for (int k = 0; k < int'(NDEST); k++)
            if (sel[k]) return k;
        return -1;
    endfunction

    function automatic bit model_ready();
        int t;
        t = lowest(bus_if.lSel);
        if (t < 0) return 1;
        return !m_valid[t] || dst_ack[t];
    endfunction

    function automatic void model_edge();
        int t;
        bit rdy;
        t   = lowest(bus_if.lSel);
        rdy = model_ready();
        for (int k = 0; k < int'(NDEST); k++) begin
            if (bus_if.bus_valid && rdy && k == t) begin
                m_data[k]  = bus_if.bus_in;
                m_valid[k] = 1;
            end else if (dst_ack[k] && m_valid[k]) begin
                m_valid[k] = 0;
            end
        end
        if (err_clr) begin
            m_err = 0;
            m_cnt = 0;
        end else if (bus_if.bus_valid && t < 0) begin
            m_err = 1;
            if (m_cnt < int'(CMAX)) m_cnt++;
        end
    endfunction

    task automatic check_state();
        logic [DW-1:0]    exp_data;
        logic [NDEST-1:0] exp_valid;
        for (int k = 0; k < int'(NDEST); k++) begin
            exp_data[k*WIDTH +: WIDTH] = m_data[k];
            exp_valid[k]               = m_valid[k];
        end
        chk("dst_valid", DW'(dst_valid), DW'(exp_valid));
        chk("dst_data", dst_data, exp_data);
        chk("err_nosel", DW'(err_nosel), DW'(m_err));
        chk("drop_cnt", DW'(drop_cnt), DW'(m_cnt));
    endtask

    // Inputs are set shortly after an edge; check ready mid-cycle, then state after the edge.
    task automatic step();
        #1;
        chk("bus_ready", DW'(bus_if.bus_ready), DW'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    task automatic drive(input bit v, input logic [NDEST-1:0] sel, input logic [WIDTH-1:0] d,
                         input logic [NDEST-1:0] ack, input bit clr);
        bus_if.bus_valid = v;
        bus_if.lSel      = sel;
        bus_if.bus_in    = d;
        dst_ack          = ack;
        err_clr          = clr;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, '0, 0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NDEST-1:0] sel;
        logic [WIDTH-1:0] word;
        bit               stalled;
        rst = 1'b1;
        drive(0, '0, '0, '0, 0);
        model_reset();
        #1;
        check_state();
        do_reset();
        check_state();

        // 1: basic capture into slot 2
        drive(1, 6'b000100, 32'hDEAD_BEEF, '0, 0);
        step();
        chk("t1_valid", DW'(dst_valid), DW'(6'b000100));
        chk("t1_slot2", DW'(dst_data[2*WIDTH +: WIDTH]), DW'(32'hDEAD_BEEF));

        // 2: stall on occupied slot, then pass-through with ack
        drive(1, 6'b000100, 32'h1234, '0, 0);
        step();
        step();
        chk("t2_stall_ready", DW'(bus_if.bus_ready), DW'(0));
        dst_ack = 6'b000100;
        step();
        chk("t2_slot2", DW'(dst_data[2*WIDTH +: WIDTH]), DW'(32'h1234));
        chk("t2_valid2", DW'(dst_valid[2]), DW'(1));

        // 3: priority resolve, lowest bit wins
        do_reset();
        drive(1, 6'b101010, 32'h5, '0, 0);
        step();
        chk("t3_valid", DW'(dst_valid), DW'(6'b000010));
        chk("t3_slot1", DW'(dst_data[1*WIDTH +: WIDTH]), DW'(32'h5));

        // 4: no-select drops with saturation, then clear
        drive(1, '0, 32'hABCD, '0, 0);
        for (int i = 0; i < 300; i++) step();
        chk("t4_err", DW'(err_nosel), DW'(1));
        chk("t4_cnt", DW'(drop_cnt), DW'(255));
        drive(0, '0, '0, '0, 1);
        step();
        chk("t4_clr_err", DW'(err_nosel), DW'(0));
        chk("t4_clr_cnt", DW'(drop_cnt), DW'(0));
        // clear wins over a simultaneous drop
        drive(1, '0, '0, '0, 1);
        step();

        // 5: dual ack while capturing a third slot
        do_reset();
        drive(1, 6'b000001, 32'h10, '0, 0);
        step();
        drive(1, 6'b100000, 32'h15, '0, 0);
        step();
        drive(1, 6'b001000, 32'h13, 6'b100001, 0);
        step();
        chk("t5_valid", DW'(dst_valid), DW'(6'b001000));

        // 6: async reset mid-cycle while slot 4 valid and word offered
        drive(1, 6'b010000, 32'h44, '0, 0);
        step();
        drive(1, 6'b010000, 32'h45, '0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_valid", DW'(dst_valid), DW'(0));
        chk("t6_rst_data", dst_data, DW'(0));
        drive(0, '0, '0, '0, 0);
        #2;
        rst = 1'b0;
        step();
        drive(1, 6'b010000, 32'h46, '0, 0);
        step();
        chk("t6_recap", DW'(dst_data[4*WIDTH +: WIDTH]), DW'(32'h46));

        // random traffic; driver holds word and select while stalled
        stalled = 0;
        sel     = '0;
        word    = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!stalled) begin
                word = $urandom;
                sel  = ($urandom_range(0, 7) == 0) ? '0 : NDEST'($urandom);
            end
            drive($urandom_range(0, 3) != 0, sel, word,
                  NDEST'($urandom) & NDEST'($urandom), $urandom_range(0, 31) == 0);
            if (i % 97 == 0) dst_ack = '0;
            #1;
            stalled = bus_if.bus_valid && !model_ready();
            #0;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
